// File: rtl/serial_subtractor.sv
// serial_subtractor: multi-cycle a - b - bin, DIGIT bits per clock, LSB slice first,
// borrow rippled between slices through a register; zero and signed-overflow flags.
module serial_subtractor #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf
);
   localparam int N = WIDTH / DIGIT;
   localparam int CW = N > 1 ? $clog2(N) : 1;
   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
   logic [1:0] state;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] ar, br, res, res_nx;
   logic a_msb, b_msb, brw, bout;
   logic [DIGIT-1:0] d;
   // operands shift right so the active slice always sits in the low DIGIT bits;
   // result slices enter at the top and reach their final position after N cycles
   assign {bout, d} = {1'b0, ar[DIGIT-1:0]} - {1'b0, br[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
   assign res_nx = WIDTH'({d, res} >> DIGIT);
   assign busy = state == RUN;
   assign done = state == DONE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt <= '0;
         ar <= '0;
         br <= '0;
         res <= '0;
         a_msb <= 1'b0;
         b_msb <= 1'b0;
         brw <= 1'b0;
         diff <= '0;
         borrow <= 1'b0;
         zero <= 1'b0;
         ovf <= 1'b0;
      end else if (state == RUN) begin
         ar <= ar >> DIGIT;
         br <= br >> DIGIT;
         res <= res_nx;
         brw <= bout;
         cnt <= cnt + CW'(1);
         if (cnt == CW'(N - 1)) begin
            state <= DONE;
            diff <= res_nx;
            borrow <= bout;
            zero <= res_nx == '0;
            ovf <= (a_msb != b_msb) && (res_nx[WIDTH-1] != a_msb);
         end
      end else if (start) begin
         state <= RUN;
         cnt <= '0;
         ar <= a;
         br <= b;
         brw <= bin;
         a_msb <= a[WIDTH-1];
         b_msb <= b[WIDTH-1];
      end else begin
         state <= IDLE;
      end
   end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for the 16/4 subtractor plus
// randomised sweeps of the (8,1), (8,8) and (12,3) configurations.
module tb_serial_subtractor;
   typedef struct packed {logic [15:0] d; logic bw; logic z; logic ov;} res_t;
   typedef struct {res_t r; int t;} exp_t;
   int checks = 0, errors = 0, cyc = 0, mcnt = 0;
   logic clk = 0, rst_n = 0, sweep_go = 0;
   logic start, bin, busy, done, borrow, zero, ovf, prev_done = 0;
   logic [15:0] a, b, diff, held = '0, hx, hy;
   exp_t q[$];
   exp_t me;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
      .busy(busy), .done(done), .diff(diff), .borrow(borrow), .zero(zero), .ovf(ovf)
   );
   // arithmetic reference on plain integers, independent of slicing
   function automatic res_t ref_sub(int w, logic [15:0] x, logic [15:0] y, logic c);
      int m = (1 << w) - 1;
      int h = 1 << (w - 1);
      int ua = int'(x) & m;
      int ub = int'(y) & m;
      int sa = ua >= h ? ua - 2 * h : ua;
      int sb = ub >= h ? ub - 2 * h : ub;
      int sr = sa - sb - int'(c);
      int r = ua - ub - int'(c);
      res_t o;
      o.d = 16'(r & m);
      o.bw = r < 0;
      o.z = (r & m) == 0;
      o.ov = sr < -h || sr >= h;
      return o;
   endfunction
   task automatic step(logic [15:0] x, logic [15:0] y, logic c, logic st, res_t e);
      @(negedge clk);
      checks++;
      if (busy !== (mcnt != 0)) begin
         errors++;
         $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, mcnt != 0);
      end
      a = x;
      b = y;
      bin = c;
      start = st;
      if (mcnt != 0) mcnt--;
      else if (st) begin
         q.push_back('{e, cyc});
         mcnt = 4;
      end
   endtask
   task automatic op(logic [15:0] x, logic [15:0] y, logic c, res_t e);
      step(x, y, c, 1'b1, e);
      repeat (5) step(16'h0, 16'h0, 1'b0, 1'b0, e);
   endtask
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (done) begin
            if (q.size() == 0) begin
               errors++;
               $display("FAIL main unexpected done diff=%h", diff);
            end else begin
               me = q.pop_front();
               if ({diff, borrow, zero, ovf} !== me.r || cyc - me.t != 5 || prev_done) begin
                  errors++;
                  $display("FAIL main result got diff=%h bw=%b z=%b ov=%b lat=%0d back2back=%b exp diff=%h bw=%b z=%b ov=%b lat=5",
                           diff, borrow, zero, ovf, cyc - me.t, prev_done, me.r.d, me.r.bw, me.r.z, me.r.ov);
               end
            end
            held <= diff;
         end else if (diff !== held) begin
            errors++;
            $display("FAIL main diff_stable got %h exp %h", diff, held);
         end
         prev_done <= done;
      end else begin
         held <= '0;
         prev_done <= 1'b0;
      end
   end
   for (genvar g = 0; g < 3; g++) begin : sw
      localparam int W = g == 2 ? 12 : 8;
      localparam int D = g == 0 ? 1 : g == 1 ? 8 : 3;
      localparam int NN = W / D;
      logic st = 0, bi = 0, fin = 0, bz, dn, bw, z, ov;
      logic [W-1:0] x = '0, y = '0, df;
      exp_t sq[$];
      exp_t se;
      serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
         .clk(clk), .rst_n(rst_n), .start(st), .a(x), .b(y), .bin(bi),
         .busy(bz), .done(dn), .diff(df), .borrow(bw), .zero(z), .ovf(ov)
      );
      always @(negedge clk) begin
         if (rst_n && dn) begin
            checks++;
            if (sq.size() == 0) begin
               errors++;
               $display("FAIL sweep%0d unexpected done", g);
            end else begin
               se = sq.pop_front();
               if (df !== se.r.d[W-1:0] || bw !== se.r.bw || z !== se.r.z || ov !== se.r.ov || cyc - se.t != NN + 1) begin
                  errors++;
                  $display("FAIL sweep%0d got diff=%h bw=%b z=%b ov=%b lat=%0d exp diff=%h bw=%b z=%b ov=%b lat=%0d",
                           g, df, bw, z, ov, cyc - se.t, se.r.d[W-1:0], se.r.bw, se.r.z, se.r.ov, NN + 1);
               end
            end
         end
      end
      initial begin
         wait (sweep_go);
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            x = W'($urandom);
            y = W'($urandom);
            bi = 1'($urandom);
            st = 1'b1;
            sq.push_back('{ref_sub(W, 16'(x), 16'(y), bi), cyc});
            @(negedge clk);
            st = 1'b0;
            for (int t = 0; t < 40 && sq.size() != 0; t++) @(negedge clk);
            if (sq.size() != 0) begin
               checks++;
               errors++;
               $display("FAIL sweep%0d timeout pending=%0d exp 0", g, sq.size());
               sq.delete();
            end
         end
         fin = 1'b1;
      end
   end
   initial begin
      start = 0;
      a = '0;
      b = '0;
      bin = 0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, diff, borrow, zero, ovf} !== '0) begin
         errors++;
         $display("FAIL reset_state got %b exp 0", {busy, done, diff, borrow, zero, ovf});
      end
      rst_n = 1;
      op(16'h1234, 16'h0234, 1'b0, {16'h1000, 3'b000});
      op(16'h0000, 16'h0001, 1'b0, {16'hFFFF, 3'b100});
      op(16'h8000, 16'h0001, 1'b0, {16'h7FFF, 3'b001});
      op(16'h0005, 16'h0004, 1'b1, {16'h0000, 3'b010});
      op(16'h0003, 16'h0003, 1'b1, {16'hFFFF, 3'b100});
      for (int i = 0; i < 20; i++) begin
         hx = 16'(i * 16'h0F37 + 16'h0101);
         hy = 16'(i * 16'h0A51);
         step(hx, hy, i[0], 1'b1, ref_sub(16, hx, hy, i[0]));
      end
      repeat (6) step(16'h0, 16'h0, 1'b0, 1'b0, '0);
      step(16'hAAAA, 16'h5555, 1'b0, 1'b1, ref_sub(16, 16'hAAAA, 16'h5555, 1'b0));
      step(16'h0, 16'h0, 1'b0, 1'b0, '0);
      @(negedge clk);
      #2 rst_n = 0;
      #1 checks++;
      if ({busy, done, diff, borrow, zero, ovf} !== '0) begin
         errors++;
         $display("FAIL async_reset got %b exp 0", {busy, done, diff, borrow, zero, ovf});
      end
      q.delete();
      mcnt = 0;
      @(negedge clk);
      #2 rst_n = 1;
      repeat (8) step(16'h0, 16'h0, 1'b0, 1'b0, '0);
      op(16'hABCD, 16'h1234, 1'b0, {16'h9999, 3'b000});
      sweep_go = 1;
      for (int t = 0; t < 5000 && !(sw[0].fin && sw[1].fin && sw[2].fin); t++) @(negedge clk);
      checks++;
      if (!(sw[0].fin && sw[1].fin && sw[2].fin)) begin
         errors++;
         $display("FAIL sweep_finish got %b%b%b exp 111", sw[2].fin, sw[1].fin, sw[0].fin);
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL main_leftover got %0d exp 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, parametrised subtractor for WIDTH-bit operands.
- Processes DIGIT bits per clock, LSB slice first, and ripples the borrow between slices through a register.
- Successor to the single-bit gate-level full subtractor. Used where a wide subtract must be area-cheap and can be time-multiplexed.
- Start/done handshake, borrow-in/borrow-out, and zero and signed-overflow flags.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be an integer multiple of DIGIT.
- DIGIT, 4, bits subtracted per cycle. Legal range is 1..WIDTH.
- N (localparam), WIDTH/DIGIT, number of RUN cycles per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new operation. Sampled only when busy=0.
- a  input  WIDTH  minuend. Captured on an accepted start.
- b  input  WIDTH  subtrahend. Captured on an accepted start.
- bin  input  1  borrow-in. Captured on an accepted start.
- busy  output  1  high while an operation is in progress (state RUN)
- done  output  1  one-cycle pulse when the result is updated
- diff  output  WIDTH  result of a - b - bin, modulo 2^WIDTH
- borrow  output  1  borrow-out from the MSB slice (1 when a < b + bin, unsigned)
- zero  output  1  diff == 0
- ovf  output  1  two's-complement overflow of a - b - bin

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously forces: state IDLE, busy=0, done=0, diff=0, borrow=0, zero=0, ovf=0, slice counter=0, internal borrow=0.
  - Reset mid-RUN aborts the operation. No done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Capture a, b and bin into working registers.
  - Clear the counter.
  - Go to RUN.
  - In DONE this allows back-to-back operation with no idle gap.
- IDLE or DONE with start=0:
  - Go to or stay in IDLE.
- RUN, each cycle i = 0..N-1:
  - Working slice = bits [i*DIGIT +: DIGIT] of the captured a and b.
  - Compute {bout, d} = a_slice - b_slice - brw, where brw = captured bin on i=0, otherwise the registered borrow of the previous slice.
  - Write d into the working result at the same slice position and register bout.
  - On i = N-1, load diff, borrow, zero and ovf from the completed result, then go to DONE.
- ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
- DONE lasts exactly one cycle. done=1 only in DONE.
- busy=1 exactly in RUN.
- start while busy=1 is ignored. It does not restart, and captured operands are unaffected.
- Latency:
  - start sampled at edge k.
  - RUN covers edges k+1..k+N.
  - done is high in the cycle following edge k+N, and diff/borrow/zero/ovf are valid in that same cycle.
  - Throughput is one result every N+1 cycles.
- diff, borrow, zero and ovf update only at the end of RUN. They hold their values through IDLE, DONE and the next RUN until the next completion.
- Inputs a, b and bin may change freely after the accepting edge.
- DIGIT == WIDTH is legal: N=1, one RUN cycle.
- DIGIT == 1 is legal: pure bit-serial operation, N=WIDTH.
- No X on any output after reset release.

Test Plan:
1. Defaults (16/4). Apply a=0x1234, b=0x0234, bin=0 with a start pulse.
   - busy high for 4 cycles, then done pulses once.
   - Required: diff=0x1000, borrow=0, zero=0, ovf=0.
2. a=0x0000, b=0x0001, bin=0.
   - Required: diff=0xFFFF, borrow=1, ovf=0.
   - Then a=0x8000, b=0x0001: required diff=0x7FFF, borrow=0, ovf=1.
3. a=0x0005, b=0x0004, bin=1.
   - Required: diff=0x0000, zero=1, borrow=0.
   - Then a=0x0003, b=0x0003, bin=1: required diff=0xFFFF, borrow=1, zero=0.
4. Handshake:
   - Assert start every cycle for 20 cycles with changing operands.
   - Required: only the operands presented in IDLE or DONE cycles are processed, one result per 5 cycles, done never high two cycles in a row, and diff is stable between done pulses.
5. Reset mid-operation:
   - Drop rst_n in the 2nd RUN cycle.
   - Required: all outputs read 0 immediately, without waiting for a clock edge.
   - After release with no start, no done pulse appears.
   - A new start gives a correct result.
6. Parameter sweep (WIDTH,DIGIT) = (8,1), (8,8), (12,3):
   - Run random operands with random bin against a reference model of a - b - bin.
   - Check diff, borrow and ovf, and check latency = N+1 cycles from start to done.
